// File: rtl/func_vector_scanner_if.sv
// Stimulus/result bundle between the vector scanner and its controller.
// The scanner drives the vector and results; the controller drives start and func_out.
interface func_vector_scanner_if;
   logic        start;
   logic        func_out;
   logic        A;
   logic        B;
   logic        C;
   logic        D;
   logic        busy;
   logic        done;
   logic [15:0] truth_table;
   logic        mismatch;
   logic [4:0]  mismatch_count;
   logic [3:0]  first_fail_idx;
   logic        xz_seen;

   modport master (
      output start,
      output func_out,
      input  A,
      input  B,
      input  C,
      input  D,
      input  busy,
      input  done,
      input  truth_table,
      input  mismatch,
      input  mismatch_count,
      input  first_fail_idx,
      input  xz_seen
   );

   modport slave (
      input  start,
      input  func_out,
      output A,
      output B,
      output C,
      output D,
      output busy,
      output done,
      output truth_table,
      output mismatch,
      output mismatch_count,
      output first_fail_idx,
      output xz_seen
   );
endinterface

// File: rtl/func_vector_scanner.sv
// Steps {A,B,C,D} through all 16 vectors, samples func_out after a settle time,
// builds the truth table and compares it against EXPECTED_TT, flagging X/Z samples.
module func_vector_scanner #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECTED_TT   = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   func_vector_scanner_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;

   logic [3:0]  idx;
   logic [3:0]  cnt;
   logic [15:0] tt;
   logic        mm;
   logic [4:0]  mcount;
   logic [3:0]  ffi;
   logic        xz;

   logic        busy_c;
   logic        done_c;

   logic        sample_xz;
   logic        sample_bit;
   logic        sample_fail;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == SETTLE_LAST) begin
               state_nxt = SAMPLE;
            end
         end
         SAMPLE: begin
            if (idx == 4'hF) begin
               state_nxt = DONE;
            end else begin
               state_nxt = SETTLE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      unique case (state)
         SETTLE:  busy_c = 1'b1;
         SAMPLE:  busy_c = 1'b1;
         DONE:    done_c = 1'b1;
         default: begin
            busy_c = 1'b0;
            done_c = 1'b0;
         end
      endcase
   end

   // A floating or contended net is recorded as 0 and always counts as a failure
   always_comb begin
      sample_xz   = $isunknown(bus.func_out);
      sample_bit  = sample_xz ? 1'b0 : bus.func_out;
      sample_fail = sample_xz || (sample_bit != EXPECTED_TT[idx]);
   end

   // Vector index, settle counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         cnt    <= '0;
         tt     <= '0;
         mm     <= 1'b0;
         mcount <= '0;
         ffi    <= '0;
         xz     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  idx    <= '0;
                  cnt    <= '0;
                  tt     <= '0;
                  mm     <= 1'b0;
                  mcount <= '0;
                  ffi    <= '0;
                  xz     <= 1'b0;
               end
            end
            SETTLE: begin
               if (cnt != SETTLE_LAST) begin
                  cnt <= cnt + 4'd1;
               end
            end
            SAMPLE: begin
               tt[idx] <= sample_bit;
               if (sample_fail) begin
                  mcount <= mcount + 5'd1;
                  if (!mm) begin
                     mm  <= 1'b1;
                     ffi <= idx;
                  end
               end
               if (sample_xz) begin
                  xz <= 1'b1;
               end
               // idx stays at 15 after the last vector so the final vector holds in IDLE
               if (idx != 4'hF) begin
                  idx <= idx + 4'd1;
                  cnt <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.A              = idx[3];
   assign bus.B              = idx[2];
   assign bus.C              = idx[1];
   assign bus.D              = idx[0];
   assign bus.busy           = busy_c;
   assign bus.done           = done_c;
   assign bus.truth_table    = tt;
   assign bus.mismatch       = mm;
   assign bus.mismatch_count = mcount;
   assign bus.first_fail_idx = ffi;
   assign bus.xz_seen        = xz;

endmodule

// File: tb/tb_func_vector_scanner.sv
// Directed bench for func_vector_scanner: four instances with different
// settle times, expected tables and func_out sources.
module tb_func_vector_scanner;

   logic clk;
   logic rst;
   logic [3:0] start_v;
   logic mode1;
   logic zval;
   logic sim4;

   int tests;
   int failures;

   logic [3:0]  busy_v;
   logic [3:0]  done_v;
   logic [3:0]  mm_v;
   logic [3:0]  xz_v;
   logic [3:0]  abcd_v [4];
   logic [15:0] tt_v   [4];
   logic [4:0]  cnt_v  [4];
   logic [3:0]  ffi_v  [4];

   func_vector_scanner_if if0 ();
   func_vector_scanner_if if1 ();
   func_vector_scanner_if if2 ();
   func_vector_scanner_if if3 ();

   func_vector_scanner #(.SETTLE_CYCLES(2), .EXPECTED_TT(16'hFF00)) u0 (.clk(clk), .rst(rst), .bus(if0));
   func_vector_scanner #(.SETTLE_CYCLES(2), .EXPECTED_TT(16'h0000)) u1 (.clk(clk), .rst(rst), .bus(if1));
   func_vector_scanner #(.SETTLE_CYCLES(2), .EXPECTED_TT(16'hF666)) u2 (.clk(clk), .rst(rst), .bus(if2));
   func_vector_scanner #(.SETTLE_CYCLES(1), .EXPECTED_TT(16'hFF00)) u3 (.clk(clk), .rst(rst), .bus(if3));

   // Behavioural stand-in for the function block: (A & B) | (C ^ D)
   function automatic logic model_f(input logic [3:0] v);
      return (v[3] & v[2]) | (v[1] ^ v[0]);
   endfunction

   assign if0.start = start_v[0];
   assign if1.start = start_v[1];
   assign if2.start = start_v[2];
   assign if3.start = start_v[3];

   assign if0.func_out = if0.A;
   assign if1.func_out = mode1 ? ((abcd_v[1] == 4'd5) ? zval : 1'b0) : if1.A;
   assign if2.func_out = model_f(abcd_v[2]);
   assign if3.func_out = if3.A;

   assign abcd_v[0] = {if0.A, if0.B, if0.C, if0.D};
   assign abcd_v[1] = {if1.A, if1.B, if1.C, if1.D};
   assign abcd_v[2] = {if2.A, if2.B, if2.C, if2.D};
   assign abcd_v[3] = {if3.A, if3.B, if3.C, if3.D};
   assign busy_v = {if3.busy, if2.busy, if1.busy, if0.busy};
   assign done_v = {if3.done, if2.done, if1.done, if0.done};
   assign mm_v   = {if3.mismatch, if2.mismatch, if1.mismatch, if0.mismatch};
   assign xz_v   = {if3.xz_seen, if2.xz_seen, if1.xz_seen, if0.xz_seen};
   assign tt_v[0] = if0.truth_table;
   assign tt_v[1] = if1.truth_table;
   assign tt_v[2] = if2.truth_table;
   assign tt_v[3] = if3.truth_table;
   assign cnt_v[0] = if0.mismatch_count;
   assign cnt_v[1] = if1.mismatch_count;
   assign cnt_v[2] = if2.mismatch_count;
   assign cnt_v[3] = if3.mismatch_count;
   assign ffi_v[0] = if0.first_fail_idx;
   assign ffi_v[1] = if1.first_fail_idx;
   assign ffi_v[2] = if2.first_fail_idx;
   assign ffi_v[3] = if3.first_fail_idx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start a scan on instance k and follow it edge by edge from acceptance (edge 0).
   task automatic run_scan(input int k, input int s, input int restart_vec,
                           input int rst_vec, input bit chk_vec);
      int per;
      int total;
      int n;
      int dones;
      bit seen;
      bit reset_hit;
      per = s + 1;
      total = 16 * per;
      n = 0;
      seen = 1'b0;
      reset_hit = 1'b0;
      @(negedge clk);
      start_v[k] = 1'b1;
      @(posedge clk);
      #1;
      start_v[k] = 1'b0;
      check_eq("busy_on_accept", 32'(busy_v[k]), 32'd1);
      while (!seen && !reset_hit && n < total + 20) begin
         if (chk_vec && n < total) check_eq("abcd_step", 32'(abcd_v[k]), 32'(n / per));
         if (restart_vec >= 0 && n == restart_vec * per) start_v[k] = 1'b1;
         if (rst_vec >= 0 && n == rst_vec * per) rst = 1'b1;
         @(posedge clk);
         #1;
         n++;
         start_v[k] = 1'b0;
         if (rst) reset_hit = 1'b1;
         else if (done_v[k]) seen = 1'b1;
      end
      if (reset_hit) begin
         check_eq("rst_busy", 32'(busy_v[k]), 32'd0);
         check_eq("rst_done", 32'(done_v[k]), 32'd0);
         check_eq("rst_abcd", 32'(abcd_v[k]), 32'd0);
         check_eq("rst_tt", 32'(tt_v[k]), 32'd0);
         check_eq("rst_cnt", 32'(cnt_v[k]), 32'd0);
         rst = 1'b0;
         dones = 0;
         repeat (total + 10) begin
            @(posedge clk);
            #1;
            if (done_v[k]) dones++;
         end
         check_eq("no_done_after_rst", 32'(dones), 32'd0);
      end else begin
         check_eq("done_edge", 32'(n), 32'(total));
         @(posedge clk);
         #1;
         check_eq("done_one_cycle", 32'(done_v[k]), 32'd0);
         check_eq("idle_busy", 32'(busy_v[k]), 32'd0);
         check_eq("idle_abcd_hold", 32'(abcd_v[k]), 32'hF);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] model_tt;
      tests = 0;
      failures = 0;
      start_v = '0;
      mode1 = 1'b0;
      zval = 1'bz;
      rst = 1'b1;
      #1;
      // A 2-state simulator cannot hold Z, so the floating sample reads as 0
      sim4 = $isunknown(zval);

      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", 32'(busy_v[0]), 32'd0);
      check_eq("reset_done", 32'(done_v[0]), 32'd0);
      check_eq("reset_abcd", 32'(abcd_v[0]), 32'd0);
      check_eq("reset_tt", 32'(tt_v[0]), 32'd0);
      check_eq("reset_mm", 32'(mm_v[0]), 32'd0);
      check_eq("reset_cnt", 32'(cnt_v[0]), 32'd0);
      check_eq("reset_ffi", 32'(ffi_v[0]), 32'd0);
      check_eq("reset_xz", 32'(xz_v[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // func_out = A, matching table, extra start at vector 7 ignored
      run_scan(0, 2, 7, -1, 1'b0);
      check_eq("a_tt", 32'(tt_v[0]), 32'hFF00);
      check_eq("a_mm", 32'(mm_v[0]), 32'd0);
      check_eq("a_cnt", 32'(cnt_v[0]), 32'd0);
      check_eq("a_xz", 32'(xz_v[0]), 32'd0);

      // func_out = A against an all-zero table
      run_scan(1, 2, -1, -1, 1'b0);
      check_eq("b_tt", 32'(tt_v[1]), 32'hFF00);
      check_eq("b_mm", 32'(mm_v[1]), 32'd1);
      check_eq("b_cnt", 32'(cnt_v[1]), 32'd8);
      check_eq("b_ffi", 32'(ffi_v[1]), 32'd8);

      // Floating output at index 5 only
      mode1 = 1'b1;
      run_scan(1, 2, -1, -1, 1'b0);
      check_eq("z_tt", 32'(tt_v[1]), 32'h0000);
      check_eq("z_tt5", 32'(tt_v[1][5]), 32'd0);
      check_eq("z_xz", 32'(xz_v[1]), sim4 ? 32'd1 : 32'd0);
      check_eq("z_cnt", 32'(cnt_v[1]), sim4 ? 32'd1 : 32'd0);
      check_eq("z_mm", 32'(mm_v[1]), sim4 ? 32'd1 : 32'd0);
      if (sim4) check_eq("z_ffi", 32'(ffi_v[1]), 32'd5);

      // Behavioural model, each vector held 3 cycles
      model_tt = '0;
      for (int i = 0; i < 16; i++) model_tt[i] = model_f(4'(i));
      run_scan(2, 2, -1, -1, 1'b1);
      check_eq("m_tt", 32'(tt_v[2]), 32'(model_tt));
      check_eq("m_mm", 32'(mm_v[2]), 32'd0);
      check_eq("m_cnt", 32'(cnt_v[2]), 32'd0);

      // Single settle cycle: 2 cycles per vector, done at edge 32
      run_scan(3, 1, -1, -1, 1'b1);
      check_eq("s1_tt", 32'(tt_v[3]), 32'hFF00);
      check_eq("s1_mm", 32'(mm_v[3]), 32'd0);

      // Reset during vector 10 of a second scan
      run_scan(0, 2, -1, 10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/func_vector_scanner.md
Name: func_vector_scanner

Overview:
- Upstream driver and result collector for the 4-input switch-level CMOS function block.
- On a start pulse it steps {A,B,C,D} through all 16 input combinations, waits a programmable settle time per vector, and samples the function output.
- Builds a 16-bit truth table, compares it against an expected table, and reports mismatches.
- Reports X/Z outputs (floating or contended nets from the transistor network) separately.

Parameters:
- SETTLE_CYCLES, 2, cycles held per vector before sampling; legal range 1..15.
- EXPECTED_TT, 16'h0000, expected truth table; bit i is the expected output for index i = {A,B,C,D}, A is the MSB.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan; accepted only in IDLE.
- func_out  input  1  output of the function block under test.
- A  output  1  vector bit 3.
- B  output  1  vector bit 2.
- C  output  1  vector bit 1.
- D  output  1  vector bit 0.
- busy  output  1  high from start acceptance until the cycle before done.
- done  output  1  one-cycle pulse when a scan completes.
- truth_table  output  16  captured outputs; bit i holds the sample for index i.
- mismatch  output  1  sticky; set if any sample differs from EXPECTED_TT or is X/Z.
- mismatch_count  output  5  number of failing vectors, 0..16.
- first_fail_idx  output  4  index of the first failing vector; valid only when mismatch=1.
- xz_seen  output  1  sticky; set if any sample was X or Z.

Behaviour:
- Reset values (rst high at an edge):
  - State IDLE.
  - {A,B,C,D}=4'b0000.
  - busy=0, done=0, truth_table=16'h0000, mismatch=0, mismatch_count=0, first_fail_idx=0, xz_seen=0.
  - Settle counter=0.
- Vector drive: {A,B,C,D} is driven directly from the 4-bit index register idx.
- States:
  - IDLE: start=1 → SETTLE. On the same edge: idx=0, settle counter=0, busy=1, and all result outputs are cleared to their reset values.
  - SETTLE: counter increments each cycle. When it reaches SETTLE_CYCLES-1 → SAMPLE.
  - SAMPLE: one cycle.
    - truth_table[idx] takes func_out.
    - A vector fails if func_out is X/Z or func_out != EXPECTED_TT[idx].
    - On the first failure: first_fail_idx=idx and mismatch=1. mismatch_count increments on every failure.
    - X/Z samples store 0 in truth_table and set xz_seen.
    - If idx==15 → DONE. Otherwise idx increments, counter clears, → SETTLE.
  - DONE: done=1 and busy=0 for exactly one cycle, then unconditionally → IDLE. start during DONE is ignored.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - If start is accepted at edge 0, done is high in the cycle following edge 16*(SETTLE_CYCLES+1). With the default this is edge 48.
- After done:
  - Results and {A,B,C,D}=4'b1111 hold in IDLE until the next accepted start.
  - idx does not wrap back to 0 on its own; it is reset only by start acceptance or rst.
- start asserted while busy: ignored, no restart.
- rst mid-scan: all outputs take their reset values on that edge, regardless of state. No done pulse is generated.
- rst and start high together: rst wins; the block is in IDLE on the next cycle.
- mismatch_count width covers the all-16-fail case without saturation logic.

Test Plan:
- func_out tied to A, EXPECTED_TT=16'hFF00, SETTLE_CYCLES=2: pulse start → done in cycle 48, truth_table=16'hFF00, mismatch=0, mismatch_count=0, xz_seen=0.
- func_out tied to A, EXPECTED_TT=16'h0000: scan → truth_table=16'hFF00, mismatch=1, mismatch_count=8, first_fail_idx=8.
- func_out driven by a bench-side behavioural model of the function, with EXPECTED_TT equal to that model's table: scan → mismatch=0.
  - Check {A,B,C,D} steps 0..15, each value held 3 cycles.
- func_out=1'bz for index 5 only, EXPECTED_TT=16'h0000, otherwise 0: scan → xz_seen=1, mismatch_count=1, first_fail_idx=5, truth_table[5]=0.
- Pulse start again at vector 7: no restart, done still in cycle 48.
  - Then assert rst at vector 10 of a second scan: next cycle busy=0, {A,B,C,D}=0, truth_table=0, and no done pulse follows.
- SETTLE_CYCLES=1: done in cycle 32; each vector is held exactly 2 cycles.
